// File: rtl/calc_op_sequencer.sv
// Sequencing front-end for the 4-bit calculator datapath: accepts one request, holds the
// operands for SETTLE_CYC cycles, captures results. Optional accumulator chaining: CALC_SEQ_ACC_EN.
module calc_op_sequencer #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CALC_SEQ_ACC_EN
  input  logic             req_chain,
`endif
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_a,
  input  logic [3:0]       req_b,
  input  logic [3:0]       req_sel,
  output logic [3:0]       alu_inp1,
  output logic [3:0]       alu_inp2,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out1,
  input  logic [7:0]       alu_out2_1,
  input  logic [7:0]       alu_out2_2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_out1,
  output logic [7:0]       rsp_out2_1,
  output logic [7:0]       rsp_out2_2,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned SETTLE_W = 4;

  generate
    if (SETTLE_CYC == 0 || SETTLE_CYC > 15) begin : g_bad_settle
      $error("calc_op_sequencer: SETTLE_CYC must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SETTLE_W-1:0] cnt;
  logic                accept;
  logic                capture;
  logic                done;
  logic [3:0]          operand1;

`ifdef CALC_SEQ_ACC_EN
  logic [3:0] acc;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)  state_nxt = S_WAIT;
      S_WAIT:  if (capture) state_nxt = S_RESP;
      S_RESP:  if (done)    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake decode from registered state
  always_comb begin
    req_ready = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    req_ready = (state == S_IDLE);
    accept    = req_valid && (state == S_IDLE);
    capture   = (state == S_WAIT) && (cnt == '0);
    done      = (state == S_RESP) && rsp_valid && rsp_ready;
  end

`ifdef CALC_SEQ_ACC_EN
  assign operand1 = req_chain ? acc : req_a;
`else
  assign operand1 = req_a;
`endif

  // Operand, settle counter, response and statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_inp1   <= '0;
      alu_inp2   <= '0;
      alu_sel    <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_out1   <= '0;
      rsp_out2_1 <= '0;
      rsp_out2_2 <= '0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        alu_inp1 <= operand1;
        alu_inp2 <= req_b;
        alu_sel  <= req_sel;
        cnt      <= SETTLE_W'(SETTLE_CYC - 1);
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - SETTLE_W'(1);
      end
      if (capture) begin
        rsp_out1   <= alu_out1;
        rsp_out2_1 <= alu_out2_1;
        rsp_out2_2 <= alu_out2_2;
        rsp_valid  <= 1'b1;
      end
      if (done) begin
        rsp_valid <= 1'b0;
        if (op_count != '1) op_count <= op_count + CNT_W'(1);
      end
    end
  end

`ifdef CALC_SEQ_ACC_EN
  // Accumulator keeps the low nibble of the last delivered result
  always_ff @(posedge clk) begin
    if (rst)       acc <= '0;
    else if (done) acc <= rsp_out1[3:0];
  end
`endif

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer with a combinational datapath stub.
// A second, narrow-counter instance shares the stimulus to exercise op_count saturation.
module tb_calc_op_sequencer;

  localparam int unsigned SETTLE  = 2;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SMALL_W = 3;

  typedef struct packed {
    logic [7:0] o1;
    logic [7:0] o21;
    logic [7:0] o22;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_chain = 1'b0;
  logic [3:0]       req_a = '0, req_b = '0, req_sel = '0;
  logic             rsp_ready = 1'b0;
  logic             req_ready, rsp_valid;
  logic [3:0]       alu_inp1, alu_inp2, alu_sel;
  logic [7:0]       alu_out1, alu_out2_1, alu_out2_2;
  logic [7:0]       rsp_out1, rsp_out2_1, rsp_out2_2;
  logic [CNT_W-1:0] op_count;

  logic               s_req_ready, s_rsp_valid;
  logic [3:0]         s_inp1, s_inp2, s_sel;
  logic [7:0]         s_out1, s_out2_1, s_out2_2;
  logic [SMALL_W-1:0] s_op_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt_exp   = 0;
  int   small_exp = 0;
  logic [3:0] acc_m = '0;
  rsp_t q[$];

  // Datapath stub
  assign alu_out1   = 8'(alu_inp1) + 8'(alu_inp2);
  assign alu_out2_1 = {4'h0, alu_inp1 & alu_inp2};
  assign alu_out2_2 = {alu_sel, 4'h0};

  calc_op_sequencer #(.SETTLE_CYC(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
`ifdef CALC_SEQ_ACC_EN
    .req_chain(req_chain),
`endif
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_sel(alu_sel),
    .alu_out1(alu_out1), .alu_out2_1(alu_out2_1), .alu_out2_2(alu_out2_2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out1(rsp_out1), .rsp_out2_1(rsp_out2_1), .rsp_out2_2(rsp_out2_2),
    .op_count(op_count)
  );

  calc_op_sequencer #(.SETTLE_CYC(SETTLE), .CNT_W(SMALL_W)) dut_small (
    .clk(clk), .rst(rst),
`ifdef CALC_SEQ_ACC_EN
    .req_chain(req_chain),
`endif
    .req_valid(req_valid), .req_ready(s_req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_inp1(s_inp1), .alu_inp2(s_inp2), .alu_sel(s_sel),
    .alu_out1(alu_out1), .alu_out2_1(alu_out2_1), .alu_out2_2(alu_out2_2),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out1(s_out1), .rsp_out2_1(s_out2_1), .rsp_out2_2(s_out2_2),
    .op_count(s_op_count)
  );

  // Scoreboard: push on accept, pop and compare on response handshake
  always @(negedge clk) begin
    rsp_t       e;
    logic [3:0] a_eff;
    if (rst) begin
      q.delete();
      cnt_exp   = 0;
      small_exp = 0;
      acc_m     = '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard: response with nothing expected, got %h/%h/%h",
                   rsp_out1, rsp_out2_1, rsp_out2_2);
        end else begin
          e = q.pop_front();
          if ({rsp_out1, rsp_out2_1, rsp_out2_2} !== e) begin
            n_fail++;
            $display("FAIL rsp_data: got %h/%h/%h expected %h/%h/%h",
                     rsp_out1, rsp_out2_1, rsp_out2_2, e.o1, e.o21, e.o22);
          end
          acc_m = e.o1[3:0];
        end
        if (cnt_exp < (1 << CNT_W) - 1) cnt_exp++;
        if (small_exp < (1 << SMALL_W) - 1) small_exp++;
      end
      if (req_valid && req_ready) begin
        a_eff = req_a;
`ifdef CALC_SEQ_ACC_EN
        if (req_chain) a_eff = acc_m;
`endif
        e.o1  = 8'(a_eff) + 8'(req_b);
        e.o21 = {4'h0, a_eff & req_b};
        e.o22 = {req_sel, 4'h0};
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after the accepting edge
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel,
                      input logic chain, input bit keep, output bit ok);
    tick();
    req_valid = 1'b1;
    req_a = a; req_b = b; req_sel = sel; req_chain = chain;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    if (!keep) req_valid = 1'b0;
  endtask

  // Count edges from accept until rsp_valid is seen
  task automatic wait_valid(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b expected 1/0", req_ready, rsp_valid);
    end
    n_checks++;
    if ({alu_inp1, alu_inp2, alu_sel} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_alu: got %h expected 000", {alu_inp1, alu_inp2, alu_sel});
    end
    n_checks++;
    if ({rsp_out1, rsp_out2_1, rsp_out2_2} !== 24'h0 || op_count !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got %h cnt=%0d expected 0 cnt=0",
               {rsp_out1, rsp_out2_1, rsp_out2_2}, op_count);
    end
  endtask

  task automatic test_basic();
    bit ok; bit okv; int lat;
    rsp_ready = 1'b1;
    send(4'd13, 4'd10, 4'b0011, 1'b0, 1'b0, ok);
    wait_valid(lat, okv);
    n_checks++;
    if (!ok || !okv || lat != SETTLE) begin
      n_fail++;
      $display("FAIL basic_latency: accepted=%b valid=%b lat=%0d expected 1/1/%0d", ok, okv, lat, SETTLE);
    end
    n_checks++;
    if ({rsp_out1, rsp_out2_1, rsp_out2_2} !== 24'h170830) begin
      n_fail++;
      $display("FAIL basic_result: got %h expected 170830", {rsp_out1, rsp_out2_1, rsp_out2_2});
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_done: rsp_valid=%b op_count=%0d expected 0/1", rsp_valid, op_count);
    end
  endtask

  task automatic test_backpressure();
    bit ok; bit okv; int lat; int c0;
    rsp_ready = 1'b0;
    c0 = cnt_exp;
    send(4'd13, 4'd10, 4'b0011, 1'b0, 1'b0, ok);
    wait_valid(lat, okv);
    n_checks++;
    if (!ok || !okv || lat != SETTLE) begin
      n_fail++;
      $display("FAIL bp_latency: accepted=%b valid=%b lat=%0d expected 1/1/%0d", ok, okv, lat, SETTLE);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      req_valid = 1'b1; req_a = 4'(i); req_b = 4'hF; req_sel = 4'hA;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || {rsp_out1, rsp_out2_1, rsp_out2_2} !== 24'h170830 ||
          req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b rsp=%h ready=%b expected 1/170830/0",
                 i, rsp_valid, {rsp_out1, rsp_out2_1, rsp_out2_2}, req_ready);
      end
      n_checks++;
      if ({alu_inp1, alu_inp2, alu_sel} !== 12'hDA3 || op_count !== 16'(c0)) begin
        n_fail++;
        $display("FAIL bp_alu[%0d]: alu=%h cnt=%0d expected da3/%0d",
                 i, {alu_inp1, alu_inp2, alu_sel}, op_count, c0);
      end
    end
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || op_count !== 16'(c0 + 1)) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b cnt=%0d expected 0/%0d", rsp_valid, op_count, c0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; bit okv; int lat;
    rsp_ready = 1'b1;
    send(4'd1, 4'd2, 4'h4, 1'b0, 1'b1, ok);
    req_a = 4'd15; req_b = 4'd15; req_sel = 4'h9;
    wait_valid(lat, okv);
    n_checks++;
    if (!ok || !okv || lat != SETTLE || rsp_out1 !== 8'h03 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: acc=%b valid=%b lat=%0d out1=%h ready=%b expected 1/1/%0d/03/0",
               ok, okv, lat, rsp_out1, req_ready, SETTLE);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_turnaround: ready=%b valid=%b expected 1/0", req_ready, rsp_valid);
    end
    tick();
    req_valid = 1'b0;
    wait_valid(lat, okv);
    n_checks++;
    if (!okv || lat != SETTLE || rsp_out1 !== 8'h1E || {alu_inp1, alu_inp2, alu_sel} !== 12'hFF9) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b lat=%0d out1=%h alu=%h expected 1/%0d/1e/ff9",
               okv, lat, rsp_out1, {alu_inp1, alu_inp2, alu_sel}, SETTLE);
    end
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({alu_inp1, alu_inp2, alu_sel} !== 12'hFF9) begin
      n_fail++;
      $display("FAIL b2b_alu_hold: alu=%h expected ff9", {alu_inp1, alu_inp2, alu_sel});
    end
  endtask

  task automatic test_reset_mid();
    bit ok; bit seen;
    rsp_ready = 1'b0;
    send(4'd7, 4'd6, 4'h5, 1'b0, 1'b0, ok);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!ok || rsp_valid !== 1'b0 || {alu_inp1, alu_inp2, alu_sel} !== 12'h000 ||
        req_ready !== 1'b1 || op_count !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: acc=%b valid=%b alu=%h ready=%b cnt=%0d expected 1/0/000/1/0",
               ok, rsp_valid, {alu_inp1, alu_inp2, alu_sel}, req_ready, op_count);
    end
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    n_checks++;
    if (seen || op_count !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: response seen=%b cnt=%0d expected 0/0", seen, op_count);
    end
  endtask

  task automatic test_saturate();
    bit ok; bit okv; int lat;
    rsp_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      send(4'(k), 4'd1, 4'(k), 1'b0, 1'b0, ok);
      wait_valid(lat, okv);
      tick();
      @(negedge clk);
      n_checks++;
      if (!ok || !okv || s_op_count !== SMALL_W'(small_exp) || op_count !== CNT_W'(cnt_exp)) begin
        n_fail++;
        $display("FAIL sat_step[%0d]: acc=%b valid=%b small=%0d exp %0d wide=%0d exp %0d",
                 k, ok, okv, s_op_count, small_exp, op_count, cnt_exp);
      end
    end
    n_checks++;
    if (s_op_count !== 3'd7 || op_count !== 16'd9) begin
      n_fail++;
      $display("FAIL sat_final: small=%0d wide=%0d expected 7/9", s_op_count, op_count);
    end
    rsp_ready = 1'b0;
  endtask

`ifdef CALC_SEQ_ACC_EN
  task automatic test_acc();
    bit ok; bit okv; int lat;
    rsp_ready = 1'b1;
    send(4'd5, 4'd3, 4'h0, 1'b0, 1'b0, ok);
    wait_valid(lat, okv);
    tick();
    send(4'd15, 4'd4, 4'h0, 1'b1, 1'b0, ok);
    wait_valid(lat, okv);
    n_checks++;
    if (!ok || !okv || alu_inp1 !== 4'd8 || rsp_out1 !== 8'h0C) begin
      n_fail++;
      $display("FAIL acc_chain: acc=%b valid=%b inp1=%0d out1=%h expected 1/1/8/0c",
               ok, okv, alu_inp1, rsp_out1);
    end
    tick();
    req_chain = 1'b0;
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
`ifdef CALC_SEQ_ACC_EN
    test_acc();
`endif
    tick();
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
